// File: rtl/fetch_if.sv
// Bundles the instruction-memory request/ack bus, the redirect input and the
// decode-side valid/ready stream seen by the fetch stage.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to imem and
// buffers {word, pc} pairs in a small circular prefetch queue for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [31:0]      RESET_ADDR = {RESET_PC[31:2], 2'b00};

    typedef enum logic {BOOT, RUN} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [31:0]        word_q [DEPTH];
    logic [31:0]        pc_q   [DEPTH];

    logic req;
    logic push;
    logic pop;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        // Request never looks at inst_ready, so decode has no path into imem.
        req  = (state_q == RUN) && (count_q < DEPTH_C) && !bus.redirect;
        push = req && bus.imem_ack;
        pop  = (count_q != '0) && bus.inst_ready;

        if (bus.redirect) begin
            state_d    = RUN;
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            state_d = RUN;
            if (push) begin
                tail_d     = tail_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_ADDR;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            word_q[tail_q] <= bus.imem_rdata;
            pc_q[tail_q]   <= fetch_pc_q;
        end
    end

    assign bus.imem_req   = req;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = (count_q != '0) ? word_q[head_q] : 32'h0;
    assign bus.inst_pc    = (count_q != '0) ? pc_q[head_q]   : 32'h0;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model, a per-cycle
// compare process, and literal checks on the boot/back-pressure/redirect cases.
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] K     = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory: 0 = zero-wait, 1 = ack on the 4th requesting cycle, 2 = random ack.
    int   mode     = 0;
    logic ack_rand = 1'b0;
    int   wcnt     = 0;
    assign bus.imem_ack   = (mode == 0) ? 1'b1 : (mode == 1) ? (wcnt == 3) : ack_rand;
    assign bus.imem_rdata = bus.imem_addr ^ K;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of {pc, word} plus the next fetch address.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc  = 32'h0;
    bit          m_run = 1'b0;
    logic [31:0] delivered[$];

    always @(posedge clk) begin
        bit m_req;
        m_req = m_run && (mq.size() < DEPTH) && !bus.redirect;
        if (rst) begin
            mq.delete();
            m_pc  = 32'h0;
            m_run = 1'b0;
            wcnt <= 0;
        end else begin
            if (m_req && !bus.imem_ack) wcnt <= wcnt + 1;
            else                        wcnt <= 0;
            if (bus.redirect) begin
                mq.delete();
                m_pc = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if (mq.size() > 0 && bus.inst_ready) void'(mq.pop_front());
                if (m_req && bus.imem_ack) begin
                    mq.push_back('{pc: m_pc, word: m_pc ^ K});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_run = 1'b1;
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            logic        e_valid;
            logic [31:0] e_inst, e_pc;
            e_valid = (mq.size() > 0);
            e_inst  = e_valid ? mq[0].word : 32'h0;
            e_pc    = e_valid ? mq[0].pc   : 32'h0;
            chk("imem_req",   {31'h0, bus.imem_req},
                {31'h0, m_run && (mq.size() < DEPTH) && !bus.redirect});
            chk("imem_addr",  bus.imem_addr, m_pc);
            chk("inst_valid", {31'h0, bus.inst_valid}, {31'h0, e_valid});
            chk("inst",       bus.inst, e_inst);
            chk("inst_pc",    bus.inst_pc, e_pc);
            if (bus.inst_valid && bus.inst_ready) delivered.push_back(bus.inst_pc);
        end
    end

    task automatic release_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = 1'b1;

        // Boot with zero-wait memory.
        repeat (2) @(negedge clk);
        @(negedge clk); rst = 1'b0;
        #2;
        chk("boot_req0",   {31'h0, bus.imem_req},   32'h0);
        chk("boot_valid0", {31'h0, bus.inst_valid}, 32'h0);
        chk("boot_inst0",  bus.inst,      32'h0);
        chk("boot_addr0",  bus.imem_addr, 32'h0);
        @(negedge clk); #2;
        chk("boot_req1",  {31'h0, bus.imem_req}, 32'h1);
        chk("boot_addr1", bus.imem_addr, 32'h0);
        @(negedge clk); #2;
        chk("boot_pc0",   bus.inst_pc,   32'h0);
        chk("boot_inst",  bus.inst,      32'hA5A5_0000);
        chk("boot_addr2", bus.imem_addr, 32'h4);
        @(negedge clk); #2;
        chk("boot_pc1",   bus.inst_pc,   32'h4);
        chk("boot_inst1", bus.inst,      32'hA5A5_0004);
        repeat (4) @(negedge clk);

        // Back-pressure from a fresh boot.
        bus.inst_ready = 1'b0;
        release_reset();
        repeat (6) @(negedge clk);
        #2;
        chk("bp_req_low", {31'h0, bus.imem_req},   32'h0);
        chk("bp_valid",   {31'h0, bus.inst_valid}, 32'h1);
        chk("bp_head_pc", bus.inst_pc,             32'h0);
        @(negedge clk);
        bus.inst_ready = 1'b1;
        delivered.delete();
        repeat (3) @(negedge clk);
        #2;
        chk("bp_del0", delivered[0], 32'h0);
        chk("bp_del1", delivered[1], 32'h4);
        chk("bp_del2", delivered[2], 32'h8);

        // Redirect with a full queue.
        @(negedge clk); bus.inst_ready = 1'b0;
        repeat (4) @(negedge clk);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_1003;
        @(negedge clk);
        bus.redirect = 1'b0;
        #2;
        chk("rd_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("rd_addr",  bus.imem_addr,           32'h0000_1000);
        chk("rd_req",   {31'h0, bus.imem_req},   32'h1);
        @(negedge clk);
        bus.inst_ready = 1'b1;
        delivered.delete();
        repeat (4) @(negedge clk);
        #2;
        chk("rd_del0", delivered[0], 32'h0000_1000);
        chk("rd_del1", delivered[1], 32'h0000_1004);

        // Wait-state memory: ack on every 4th requesting cycle.
        @(negedge clk);
        mode            = 1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_2000;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.redirect = 1'b0;
                delivered.delete();
            end
        end
        #2;
        chk("ws_count", 32'(delivered.size()), 32'd4);
        chk("ws_del0",  delivered[0], 32'h0000_2000);
        chk("ws_del3",  delivered[3], 32'h0000_200C);

        // Address wrap-around.
        @(negedge clk);
        mode            = 0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        bus.redirect = 1'b0;
        delivered.delete();
        repeat (6) @(negedge clk);
        #2;
        chk("wr_del0", delivered[0], 32'hFFFF_FFF8);
        chk("wr_del1", delivered[1], 32'hFFFF_FFFC);
        chk("wr_del2", delivered[2], 32'h0000_0000);
        chk("wr_del3", delivered[3], 32'h0000_0004);

        // Randomized traffic against the model.
        mode = 2;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            ack_rand        = ($urandom_range(0, 3) != 0);
            bus.inst_ready  = ($urandom_range(0, 9) < 7);
            bus.redirect    = ($urandom_range(0, 11) == 0);
            bus.redirect_pc = $urandom;
            if ($urandom_range(0, 4) == 0) bus.redirect_pc[31:4] = 28'hFFFF_FFF;
        end
        @(negedge clk);
        bus.redirect = 1'b0;

        // Reset with a full queue while ack is asserted.
        mode           = 0;
        bus.inst_ready = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rs_req",   {31'h0, bus.imem_req},   32'h0);
        chk("rs_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("rs_inst",  bus.inst,                32'h0);
        chk("rs_pc",    bus.inst_pc,             32'h0);
        chk("rs_addr",  bus.imem_addr,           32'h0);
        @(negedge clk); #2;
        chk("rs_req1",  {31'h0, bus.imem_req}, 32'h1);
        chk("rs_addr1", bus.imem_addr,         32'h0);
        @(negedge clk); #2;
        chk("rs_head",  bus.inst_pc, 32'h0);
        chk("rs_word",  bus.inst,    32'hA5A5_0000);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
